muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit.
- Sits directly downstream of the register file: consumes the two source-operand read values plus destination index, and produces a result and destination index for the writeback path into the register file.
- Sequential: one operation in flight, one bit per cycle, valid/ready handshakes on both sides.

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle
// on operand magnitudes, sign-corrected on the final step; valid/ready on both sides.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [2:0]        op_r;
    logic              neg_x, neg_a;
    logic [XLEN-1:0]   addend, hi, lo, hi_n, lo_n;
    logic [CW-1:0]     counter;
    logic              last, accept, special;
    logic              sign_a, sign_b, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res;
    logic [XLEN:0]     sum, shifted;
    logic [XLEN-1:0]   diff;
    logic              ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    // Operand decode on the request side
    always_comb begin
        sign_a      = (funct3 == 3'b001) | (funct3 == 3'b010) |
                      (funct3 == 3'b100) | (funct3 == 3'b110);
        sign_b      = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        a_neg       = sign_a & op_a[XLEN-1];
        b_neg       = sign_b & op_b[XLEN-1];
        mag_a       = a_neg ? -op_a : op_a;
        mag_b       = b_neg ? -op_b : op_b;
        b_zero      = (op_b == '0);
        ovf         = ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
        special     = funct3[2] & (b_zero | ovf);
        special_res = b_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
        accept      = in_valid & in_ready & ~flush;
        last        = (counter == CW'(XLEN-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = special ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // hi:lo is the product for multiplies and remainder:quotient for divides
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
        shifted = {hi, lo[XLEN-1]};
        ge      = (shifted >= {1'b0, addend});
        diff    = shifted[XLEN-1:0] - addend;
        if (op_r[2]) begin
            hi_n = ge ? diff : shifted[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = neg_x ? -prod : prod;
        quo_s  = neg_x ? -lo_n : lo_n;
        rem_s  = neg_a ? -hi_n : hi_n;
        case (op_r)
            3'b000:                 final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_s;
            default:                final_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= '0;
            rd_out  <= '0;
            neg_x   <= 1'b0;
            neg_a   <= 1'b0;
            addend  <= '0;
            hi      <= '0;
            lo      <= '0;
            counter <= '0;
            result  <= '0;
        end else if (accept) begin
            op_r    <= funct3;
            rd_out  <= rd_in;
            neg_x   <= a_neg ^ b_neg;
            neg_a   <= a_neg;
            addend  <= funct3[2] ? mag_b : mag_a;
            hi      <= '0;
            lo      <= funct3[2] ? mag_a : mag_b;
            counter <= '0;
            if (special) result <= special_res;
        end else if (state == CALC && !flush) begin
            hi      <= hi_n;
            lo      <= lo_n;
            counter <= counter + CW'(1);
            if (last) result <= final_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops
// checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, measure accept-to-valid edges, optionally stall in DONE, then retire it.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int stall,
                          input logic [31:0] exp);
        int edges;
        int bad;
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        funct3    = f3;
        op_a      = a;
        op_b      = b;
        rd_in     = rd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        edges    = 1;
        bad      = 0;
        while (!out_valid && edges < 40) begin
            if (in_ready) bad++;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(ref_latency(f3, a, b)));
        check({tag, " in_ready_low_calc"}, 32'(bad), 32'd0);
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, " busy_done"}, 32'(busy), 32'd1);
        if (stall > 0) begin
            bad = 0;
            repeat (stall) begin
                @(posedge clk); #1;
                if (!out_valid || result !== exp || rd_out !== rd || in_ready) bad++;
            end
            check({tag, " stall_stable"}, 32'(bad), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int bad;
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        funct3    = '0;
        op_a      = '0;
        op_b      = '0;
        rd_in     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x6",   3'd0, 32'd7, 32'd6, 5'd5, 0, 32'd42);
        run_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0, 32'h4000_0000);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 32'hFFFF_FFFF);
        run_op("mulhu_m1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 32'hFFFF_FFFE);
        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 32'hFFFF_FFFD);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 32'hFFFF_FFFF);
        run_op("divu_big",  3'd5, 32'hFFFF_FFFE, 32'd2, 5'd7, 0, 32'h7FFF_FFFF);
        run_op("div_by0",   3'd4, 32'd9, 32'd0, 5'd8, 0, 32'hFFFF_FFFF);
        run_op("remu_by0",  3'd7, 32'd9, 32'd0, 5'd9, 0, 32'd9);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 32'h8000_0000);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 32'h0);
        run_op("divu_nosp", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 32'h0);
        run_op("mul_stall", 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd0, 10, 32'hFFFF_FFF1);
        run_op("b2b_second", 3'd7, 32'd100, 32'd7, 5'd13, 0, 32'd2);

        // flush at counter=10
        in_valid = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd14;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush busy", 32'(busy), 32'd0);
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || busy) bad++;
        end
        check("flush no_out_valid", 32'(bad), 32'd0);

        // request together with flush is dropped
        in_valid = 1'b1; flush = 1'b1; funct3 = 3'd4; op_a = 32'd9; op_b = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_req busy", 32'(busy), 32'd0);
        check("flush_req out_valid", 32'(out_valid), 32'd0);

        // async reset mid-CALC
        in_valid = 1'b1; funct3 = 3'd1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; rd_in = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("midcalc busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async in_ready", 32'(in_ready), 32'd1);
        check("async busy", 32'(busy), 32'd0);
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async result", result, 32'd0);
        check("async rd_out", 32'(rd_out), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset", 3'd4, 32'd100, 32'hFFFF_FFF9, 5'd22, 0, 32'hFFFF_FFF2);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   ref_res(f3, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
